// File: rtl/datapath_mc_pkg.sv
// Shared encodings for the multi-cycle datapath: ALU ops, shift modes, FSM states.
package datapath_mc_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_WB    = 2'b11
  } state_e;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: ADD/SUB with carry and signed overflow, bitwise AND/OR.
module dp_alu
  import datapath_mc_pkg::*;
#(
  parameter int M = 8
) (
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  input  logic [1:0]   op_i,
  output logic [M-1:0] result_o,
  output logic         carry_o,
  output logic         ov_o
);

  logic [M-1:0] b_eff;
  logic [M:0]   sum;

  // SUB is A + ~B + 1, so carry-out means "no borrow" and one overflow rule serves both.
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    ov_o     = 1'b0;
    b_eff    = (op_i == ALU_SUB) ? ~b_i : b_i;
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {{M{1'b0}}, (op_i == ALU_SUB)};
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        result_o = sum[M-1:0];
        carry_o  = sum[M];
        ov_o     = (a_i[M-1] == b_eff[M-1]) && (sum[M-1] != a_i[M-1]);
      end
      ALU_AND: result_o = a_i & b_i;
      default: result_o = a_i | b_i;
    endcase
  end

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle execution core: register file, ALU, 1-bit/cycle shifter and
// write-back flags sequenced by an IDLE/EXEC/SHIFT/WB FSM behind valid/ready.
module datapath_mc
  import datapath_mc_pkg::*;
#(
  parameter int             N    = 8,
  parameter int             M    = 8,
  parameter int             P    = 3,
  parameter int             SW   = 3,
  parameter logic [N*M-1:0] INIT = {{(N-2)*M{1'b0}}, M'(1), M'(1)}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_alu,
  input  logic [1:0]    cmd_sh,
  input  logic [SW-1:0] cmd_amt,
  input  logic [P-1:0]  cmd_ra,
  input  logic [P-1:0]  cmd_rb,
  input  logic [P-1:0]  cmd_rd,
  input  logic          cmd_imm_en,
  input  logic [M-1:0]  cmd_imm,
  input  logic          cmd_we,
  output logic          done,
  output logic          fov,
  output logic          fcarry,
  output logic          fneg,
  output logic          fzero,
  input  logic [P-1:0]  dbg_sel,
  output logic [M-1:0]  dbg_data
);

  state_e        state_q, state_d;
  logic [M-1:0]  regs_q [N];

  // latched command
  alu_op_e       alu_q;
  sh_op_e        sh_q;
  logic [SW-1:0] amt_q;
  logic [P-1:0]  ra_q, rb_q, rd_q;
  logic          imm_en_q, we_q;
  logic [M-1:0]  imm_q;

  // working register, shift counter and pending flags
  logic [M-1:0]  w_q, w_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          carry_t_q, carry_t_d;
  logic          ov_t_q, ov_t_d;

  logic [M-1:0]  op_a, op_b, alu_res;
  logic          alu_c, alu_ov;

  // Operands come from the register file during EXEC, so a write-back to ra/rb is never stale.
  assign op_a      = regs_q[ra_q];
  assign op_b      = imm_en_q ? imm_q : regs_q[rb_q];
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign done      = (state_q == ST_WB);
  assign dbg_data  = regs_q[dbg_sel];

  dp_alu #(.M(M)) u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .op_i     (alu_q),
    .result_o (alu_res),
    .carry_o  (alu_c),
    .ov_o     (alu_ov)
  );

  // Next-state logic plus the W/counter/pending-flag datapath for each phase.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    carry_t_d = carry_t_q;
    ov_t_d    = ov_t_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        w_d       = alu_res;
        carry_t_d = alu_c;
        ov_t_d    = alu_ov;
        cnt_d     = amt_q;
        state_d   = (sh_q != SH_NONE && amt_q != '0) ? ST_SHIFT : ST_WB;
      end
      ST_SHIFT: begin
        case (sh_q)
          SH_LSL: begin
            w_d       = {w_q[M-2:0], 1'b0};
            carry_t_d = w_q[M-1];
          end
          SH_LSR: begin
            w_d       = {1'b0, w_q[M-1:1]};
            carry_t_d = w_q[0];
          end
          SH_ASR: begin
            w_d       = {w_q[M-1], w_q[M-1:1]};
            carry_t_d = w_q[0];
          end
          default: w_d = w_q;
        endcase
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) state_d = ST_WB;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, working registers and the command latch taken on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      w_q       <= '0;
      cnt_q     <= '0;
      carry_t_q <= 1'b0;
      ov_t_q    <= 1'b0;
      alu_q     <= ALU_ADD;
      sh_q      <= SH_NONE;
      amt_q     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rd_q      <= '0;
      imm_en_q  <= 1'b0;
      imm_q     <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      cnt_q     <= cnt_d;
      carry_t_q <= carry_t_d;
      ov_t_q    <= ov_t_d;
      if (state_q == ST_IDLE && cmd_valid) begin
        alu_q    <= alu_op_e'(cmd_alu);
        sh_q     <= sh_op_e'(cmd_sh);
        amt_q    <= cmd_amt;
        ra_q     <= cmd_ra;
        rb_q     <= cmd_rb;
        rd_q     <= cmd_rd;
        imm_en_q <= cmd_imm_en;
        imm_q    <= cmd_imm;
        we_q     <= cmd_we;
      end
    end
  end

  // Flags are committed only in WB, even for compare-only (we=0) commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fov    <= 1'b0;
      fcarry <= 1'b0;
      fneg   <= 1'b0;
      fzero  <= 1'b0;
    end else if (state_q == ST_WB) begin
      fov    <= ov_t_q;
      fcarry <= carry_t_q;
      fneg   <= w_q[M-1];
      fzero  <= (w_q == '0);
    end
  end

  // Register file: reset image from INIT, single write port used in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs_q[i] <= INIT[M*i +: M];
    end else if (state_q == ST_WB && we_q) begin
      regs_q[rd_q] <= w_q;
    end
  end

endmodule
